// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard sequencer: FSM state encoding
// and the default divider latency.
package hazard_pkg;

  localparam int DIV_LATENCY_DEFAULT = 32;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    DIV_WAIT = 2'd1,
    DIV_DONE = 2'd2
  } hz_state_e;

endpackage : hazard_pkg

// File: rtl/hazard_sequencer.sv
// Pipeline hazard sequencer: redirect flushes, load-use interlock and a
// multi-cycle divide stall, with a combinational output decoder.
module hazard_sequencer
  import hazard_pkg::*;
#(
  parameter int DIV_LATENCY = DIV_LATENCY_DEFAULT
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       ex_valid,
  input  logic [4:0] ex_rd,
  input  logic       ex_mem_read,
  input  logic       ex_div_start,
  input  logic       ex_redirect,
  output logic       stall_pc,
  output logic       stall_if_id,
  output logic       stall_id_ex,
  output logic       flush_if_id,
  output logic       flush_id_ex,
  output logic       flush_ex_mem,
  output logic       div_busy,
  output logic       div_done,
  output logic [1:0] state
);

  localparam int              CNT_W    = $clog2(DIV_LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  hz_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic redirect_hit, div_hit, load_use_hit;
  logic stall_pc_c, stall_if_id_c, stall_id_ex_c;
  logic flush_if_id_c, flush_id_ex_c, flush_ex_mem_c;
  logic div_busy_c, div_done_c;

  assign redirect_hit = ex_valid & ex_redirect;
  assign div_hit      = ex_valid & ex_div_start;
  assign load_use_hit = ex_valid & ex_mem_read & id_valid & (ex_rd != 5'd0) &
                        ((ex_rd == id_rs1) | (ex_rd == id_rs2));

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    stall_pc_c     = 1'b0;
    stall_if_id_c  = 1'b0;
    stall_id_ex_c  = 1'b0;
    flush_if_id_c  = 1'b0;
    flush_id_ex_c  = 1'b0;
    flush_ex_mem_c = 1'b0;
    div_busy_c     = 1'b0;
    div_done_c     = 1'b0;

    case (state_q)
      RUN: begin
        if (redirect_hit) begin
          flush_if_id_c = 1'b1;
          flush_id_ex_c = 1'b1;
        end else if (div_hit) begin
          stall_pc_c     = 1'b1;
          stall_if_id_c  = 1'b1;
          stall_id_ex_c  = 1'b1;
          flush_ex_mem_c = 1'b1;
          div_busy_c     = 1'b1;
          cnt_d          = CNT_LOAD;
          state_d        = DIV_WAIT;
        end else if (load_use_hit) begin
          stall_pc_c    = 1'b1;
          stall_if_id_c = 1'b1;
          flush_id_ex_c = 1'b1;
        end
      end

      DIV_WAIT: begin
        // Everything frozen; the divider owns EX until the count runs out.
        stall_pc_c     = 1'b1;
        stall_if_id_c  = 1'b1;
        stall_id_ex_c  = 1'b1;
        flush_ex_mem_c = 1'b1;
        div_busy_c     = 1'b1;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end
        if (cnt_q <= CNT_ONE) begin
          state_d = DIV_DONE;
        end
      end

      DIV_DONE: begin
        // The finishing divide is still in EX, so its start flag is ignored.
        div_done_c = 1'b1;
        cnt_d      = '0;
        state_d    = RUN;
        if (redirect_hit) begin
          flush_if_id_c = 1'b1;
          flush_id_ex_c = 1'b1;
        end else if (load_use_hit) begin
          stall_pc_c    = 1'b1;
          stall_if_id_c = 1'b1;
          flush_id_ex_c = 1'b1;
        end
      end

      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs are forced low while reset is held, regardless of live inputs.
  assign stall_pc     = rstn & stall_pc_c;
  assign stall_if_id  = rstn & stall_if_id_c;
  assign stall_id_ex  = rstn & stall_id_ex_c;
  assign flush_if_id  = rstn & flush_if_id_c;
  assign flush_id_ex  = rstn & flush_id_ex_c;
  assign flush_ex_mem = rstn & flush_ex_mem_c;
  assign div_busy     = rstn & div_busy_c;
  assign div_done     = rstn & div_done_c;
  assign state        = state_q;

endmodule : hazard_sequencer

// File: tb/tb_hazard_sequencer.sv
// Bench for hazard_sequencer: two instances (latency 4 and 32) share stimulus
// and are checked every cycle against a stall-budget model, plus literal checks.
module tb_hazard_sequencer;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       id_valid = 1'b0;
  logic [4:0] id_rs1 = 5'd0;
  logic [4:0] id_rs2 = 5'd0;
  logic       ex_valid = 1'b0;
  logic [4:0] ex_rd = 5'd0;
  logic       ex_mem_read = 1'b0;
  logic       ex_div_start = 1'b0;
  logic       ex_redirect = 1'b0;

  logic spc[2], sifid[2], sidex[2], fifid[2], fidex[2], fexmem[2], busy[2], done[2];
  logic [1:0] st[2];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  hazard_sequencer #(.DIV_LATENCY(4)) dut4 (
    .clk(clk), .rstn(rstn), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .ex_div_start(ex_div_start), .ex_redirect(ex_redirect),
    .stall_pc(spc[0]), .stall_if_id(sifid[0]), .stall_id_ex(sidex[0]),
    .flush_if_id(fifid[0]), .flush_id_ex(fidex[0]), .flush_ex_mem(fexmem[0]),
    .div_busy(busy[0]), .div_done(done[0]), .state(st[0])
  );

  hazard_sequencer dut32 (
    .clk(clk), .rstn(rstn), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .ex_div_start(ex_div_start), .ex_redirect(ex_redirect),
    .stall_pc(spc[1]), .stall_if_id(sifid[1]), .stall_id_ex(sidex[1]),
    .flush_if_id(fifid[1]), .flush_id_ex(fidex[1]), .flush_ex_mem(fexmem[1]),
    .div_busy(busy[1]), .div_done(done[1]), .state(st[1])
  );

  // Model: cycles of divide wait still owed, and whether a done cycle is due.
  int lat[2]    = '{4, 32};
  int m_wait[2] = '{0, 0};
  bit m_done[2] = '{1'b0, 1'b0};

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 2; i++) begin
        m_wait[i] = 0;
        m_done[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (m_wait[i] > 0) begin
          m_wait[i] = m_wait[i] - 1;
          if (m_wait[i] == 0) m_done[i] = 1'b1;
        end else if (m_done[i]) begin
          m_done[i] = 1'b0;
        end else if (ex_valid && ex_div_start && !ex_redirect) begin
          m_wait[i] = lat[i] - 1;
        end
      end
    end
  end

  // Packed order: stall_pc stall_if_id stall_id_ex flush_if_id flush_id_ex
  //               flush_ex_mem div_busy div_done state[1:0]
  function automatic logic [9:0] model_vec(int i);
    logic redir, lu, dstart;
    logic [9:0] v;
    v      = 10'd0;
    redir  = ex_valid && ex_redirect;
    dstart = ex_valid && ex_div_start;
    lu     = ex_valid && ex_mem_read && id_valid && (ex_rd != 5'd0) &&
             (ex_rd == id_rs1 || ex_rd == id_rs2);
    if (!rstn) return 10'd0;
    if (m_wait[i] > 0) begin
      v = 10'b1110_0110_01;
    end else begin
      if (m_done[i]) begin
        v[2]   = 1'b1;
        v[1:0] = 2'd2;
      end
      if (redir) begin
        v[6] = 1'b1;
        v[5] = 1'b1;
      end else if (dstart && !m_done[i]) begin
        v[9] = 1'b1; v[8] = 1'b1; v[7] = 1'b1; v[4] = 1'b1; v[3] = 1'b1;
      end else if (lu) begin
        v[9] = 1'b1; v[8] = 1'b1; v[5] = 1'b1;
      end
    end
    return v;
  endfunction

  function automatic logic [9:0] dut_vec(int i);
    return {spc[i], sifid[i], sidex[i], fifid[i], fidex[i], fexmem[i],
            busy[i], done[i], st[i]};
  endfunction

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (dut_vec(i) !== model_vec(i)) begin
        n_bad++;
        $display("FAIL cycle_vec dut%0d t=%0t actual=%b required=%b",
                 lat[i], $time, dut_vec(i), model_vec(i));
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic set_in(input logic ev, input logic [4:0] rd, input logic mr,
                        input logic ds, input logic rdr, input logic iv,
                        input logic [4:0] r1, input logic [4:0] r2);
    ex_valid = ev; ex_rd = rd; ex_mem_read = mr; ex_div_start = ds;
    ex_redirect = rdr; id_valid = iv; id_rs1 = r1; id_rs2 = r2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int  n;
    bit  got;
    repeat (3) @(posedge clk);
    settle();
    chk("rst_state", 32'(st[0]), 32'd0);
    chk("rst_outs", 32'(dut_vec(0)), 32'd0);
    @(posedge clk);
    #2 rstn = 1'b1;

    cyc(); set_in(0, 0, 0, 0, 0, 0, 0, 0);
    settle(); chk("idle", 32'(dut_vec(0)), 32'd0);
    $display("txn idle");

    cyc(); set_in(1, 5'd5, 1, 0, 0, 1, 5'd3, 5'd5);
    settle();
    chk("lu_stall_pc", 32'(spc[0]), 32'd1);
    chk("lu_stall_if_id", 32'(sifid[0]), 32'd1);
    chk("lu_flush_id_ex", 32'(fidex[0]), 32'd1);
    chk("lu_stall_id_ex", 32'(sidex[0]), 32'd0);
    $display("txn load-use rd=5 rs2=5");

    cyc(); set_in(0, 0, 0, 0, 0, 0, 0, 0);
    settle(); chk("lu_one_cycle", 32'(spc[0]), 32'd0);

    cyc(); set_in(1, 5'd0, 1, 0, 0, 1, 5'd0, 5'd7);
    settle(); chk("lu_x0", 32'(spc[0]), 32'd0);
    $display("txn load-use rd=x0");

    cyc(); set_in(1, 5'd9, 1, 0, 0, 1, 5'd9, 5'd1);
    settle(); chk("lu_rs1", 32'(spc[0]), 32'd1);
    $display("txn load-use rd=9 rs1=9");

    cyc(); set_in(1, 5'd9, 1, 0, 0, 0, 5'd9, 5'd1);
    settle(); chk("lu_id_invalid", 32'(spc[0]), 32'd0);

    cyc(); set_in(1, 5'd5, 1, 0, 1, 1, 5'd5, 5'd5);
    settle();
    chk("redir_flush_if_id", 32'(fifid[0]), 32'd1);
    chk("redir_flush_id_ex", 32'(fidex[0]), 32'd1);
    chk("redir_no_stall", 32'(spc[0]), 32'd0);
    $display("txn redirect over load-use");

    cyc(); set_in(1, 5'd0, 0, 1, 1, 0, 0, 0);
    settle();
    chk("redir_div_flush", 32'(fifid[0]), 32'd1);
    chk("redir_div_busy", 32'(busy[0]), 32'd0);
    cyc(); set_in(0, 0, 0, 0, 0, 0, 0, 0);
    settle();
    chk("redir_div_state4", 32'(st[0]), 32'd0);
    chk("redir_div_state32", 32'(st[1]), 32'd0);
    $display("txn redirect with div start");

    // Divide on both instances; start held through the latency-4 done cycle.
    for (int k = 0; k < 7; k++) begin
      cyc();
      if (k <= 4) set_in(1, 5'd6, (k == 4), 1, (k == 2), 1, 5'd6, 5'd0);
      else        set_in(0, 0, 0, 0, 0, 0, 0, 0);
      settle();
      chk($sformatf("div4_busy_c%0d", k), 32'(busy[0]), (k < 4) ? 32'd1 : 32'd0);
      chk($sformatf("div4_done_c%0d", k), 32'(done[0]), (k == 4) ? 32'd1 : 32'd0);
      if (k == 1) chk("div4_state_wait", 32'(st[0]), 32'd1);
      if (k == 4) chk("div4_state_done", 32'(st[0]), 32'd2);
      if (k == 4) chk("div4_done_lu", 32'(spc[0]), 32'd1);
      if (k == 5) chk("div4_state_run", 32'(st[0]), 32'd0);
      $display("txn div4 cycle %0d busy=%0b done=%0b", k, busy[0], done[0]);
    end

    got = 1'b0;
    for (int t = 0; t < 60 && !got; t++) begin
      if (done[1]) got = 1'b1;
      if (!got) begin
        cyc();
        settle();
      end
    end
    chk("div32_first_done", 32'(got), 32'd1);
    cyc(); settle();

    // Reset mid-divide on the 32-cycle instance, with a redirect live.
    cyc(); set_in(1, 0, 0, 1, 0, 0, 0, 0);
    cyc(); set_in(0, 0, 0, 0, 0, 0, 0, 0);
    cyc();
    #1 rstn = 1'b0;
    set_in(1, 0, 0, 0, 1, 0, 0, 0);
    #1;
    chk("rst_mid_outs", 32'(dut_vec(1)), 32'd0);
    chk("rst_mid_state", 32'(st[1]), 32'd0);
    $display("txn reset mid-divide");
    cyc(); cyc();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #3 rstn = 1'b1;

    cyc(); set_in(1, 0, 0, 1, 0, 0, 0, 0);
    n = 0;
    got = 1'b0;
    for (int t = 0; t < 80 && !got; t++) begin
      settle();
      if (busy[1]) n++;
      if (done[1]) got = 1'b1;
      if (!got) begin
        cyc();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
      end
    end
    chk("div32_after_rst_done", 32'(got), 32'd1);
    chk("div32_stall_cycles", 32'(n), 32'd32);
    $display("txn div32 after reset stall cycles=%0d", n);

    cyc(); settle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_hazard_sequencer
